trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Machine-mode trap sequencer for the RV32 core. Watches the retiring instruction's exception flags, pending interrupt lines and MRET. Issues single-cycle commands to the CSR file:
- mie_clear / mie_set to the mstatus register
- capture strobes for mepc / mcause
It also drives the redirect PC and flush to the fetch stage. It sits directly upstream of the mstatus, mepc and mcause registers and consumes their current values.

Parameters:
- CODE_W, 4, width of the exception/interrupt code field in cause_out[CODE_W-1:0].

Ports:
- clk_in  input  1  core clock.
- rst_in  input  1  reset; synchronous, active-high.
- instr_valid_in  input  1  the current instruction is valid and eligible to retire this cycle.
- pc_in  input  32  PC of the current instruction.
- misaligned_in  input  1  instruction-address-misaligned exception.
- illegal_in  input  1  illegal-instruction exception.
- ecall_in  input  1  ECALL decoded.
- ebreak_in  input  1  EBREAK decoded.
- mret_in  input  1  MRET decoded.
- mie_in  input  1  mstatus.MIE, the global interrupt enable.
- meie_in, msie_in, mtie_in  input  1 each  per-source enables from the mie CSR.
- meip_in, msip_in, mtip_in  input  1 each  level pending lines for external, software and timer interrupts.
- mtvec_in  input  32  current mtvec CSR value.
- mepc_in  input  32  current mepc CSR value.
- mie_clear_out  output  1  trap entry: mstatus saves MPIE<=MIE and clears MIE.
- mie_set_out  output  1  MRET: mstatus restores MIE<=MPIE and sets MPIE.
- set_epc_out  output  1  mepc write strobe.
- epc_out  output  32  value to write into mepc.
- set_cause_out  output  1  mcause write strobe.
- cause_out  output  32  mcause value: bit31 = interrupt flag, low CODE_W bits = code.
- pc_sel_out  output  2  fetch redirect select: 00 none, 01 trap vector, 10 mepc.
- redirect_pc_out  output  32  redirect target.
- flush_out  output  1  kill all in-flight instructions.

Behaviour:
- FSM states: OPERATING, TRAP_ENTER, TRAP_RETURN. Reset goes to OPERATING.
- All outputs are registered. On reset every output is 0, including epc_out, cause_out and redirect_pc_out.
- Enabled interrupt: irq_x = mie_in & x_ie & x_ip.
- Interrupt priority: external (code 11) > software (3) > timer (7).
- Exception priority: misaligned (0) > illegal (2) > ecall (11) > ebreak (3).
- Priority between classes: any enabled interrupt > any exception > mret.
- OPERATING, when instr_valid_in=1:
  - interrupt or exception present: latch epc_out=pc_in and cause_out={is_irq, 27'b0, code} zero-extended; go to TRAP_ENTER.
  - otherwise mret_in=1: go to TRAP_RETURN.
  - otherwise: stay in OPERATING.
- OPERATING, when instr_valid_in=0: all inputs are ignored and the FSM stays in OPERATING. A pending interrupt waits for the next valid instruction.
- TRAP_ENTER lasts exactly 1 cycle and asserts mie_clear_out, set_epc_out, set_cause_out, flush_out, with pc_sel_out=01.
- redirect_pc_out in TRAP_ENTER:
  - mtvec_in[1:0]==01 and interrupt: {mtvec_in[31:2],2'b00} + (code<<2), computed mod 2^32.
  - all other cases: {mtvec_in[31:2],2'b00}.
- TRAP_ENTER always returns to OPERATING.
- TRAP_RETURN lasts exactly 1 cycle and asserts mie_set_out and flush_out, with pc_sel_out=10 and redirect_pc_out={mepc_in[31:1],1'b0}. It always returns to OPERATING.
- Latency: the trap or MRET is detected at the clock edge that ends cycle N; strobes, redirect and flush are high throughout cycle N+1.
- In TRAP_ENTER and TRAP_RETURN all trap, mret and irq inputs are ignored, so back-to-back traps are separated by at least 1 OPERATING cycle.
- mie_clear_out and mie_set_out are never high together. Every strobe is a single-cycle pulse.
- epc_out and cause_out hold their last latched value outside TRAP_ENTER; only the strobes gate the writes.
- MRET is ignored for the cycle if any exception or enabled interrupt is present in the same cycle (e.g. MRET + illegal_in: trap with cause 2).
- Reset asserted in TRAP_ENTER or TRAP_RETURN: the next cycle is OPERATING with all outputs 0 and no strobe. A trap in progress is dropped.
- mie_in is sampled in the detection cycle only. The MIE clear issued in TRAP_ENTER takes effect in mstatus at the end of that cycle, which suppresses nested interrupts.

Test Plan:
- Reset then idle: rst_in high 2 cycles, then instr_valid_in=1 with no events → all outputs 0 and the FSM stays in OPERATING.
- Illegal instruction: pc_in=0x0000_0100, illegal_in=1, mtvec_in=0x0000_0041 → next cycle:
  - set_epc_out=1, epc_out=0x100
  - cause_out=0x0000_0002
  - pc_sel_out=01, redirect_pc_out=0x40 (synchronous exceptions always use the base, even in vectored mode)
  - mie_clear_out=1, flush_out=1
  - the cycle after, all strobes are 0.
- Vectored timer interrupt: mie_in=1, mtie_in=1, mtip_in=1, mtvec_in=0x0000_0201, pc_in=0x80 → cause_out=0x8000_0007, redirect_pc_out=0x21C, epc_out=0x80.
- Priority: meip/msip/mtip all enabled and pending plus ecall_in=1 → cause_out=0x8000_000B. Repeat with mie_in=0 → cause_out=0x0000_000B.
- MRET: mret_in=1, mepc_in=0x0000_0105 → mie_set_out=1, pc_sel_out=10, redirect_pc_out=0x104, flush_out=1, mie_clear_out=0. Repeat with ebreak_in=1 in the same cycle → trap with cause 3 and no mie_set_out.
- Reset mid-trap: trigger ecall, then assert rst_in in the TRAP_ENTER cycle → the following cycle shows all outputs 0 and no mie_clear_out pulse.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. It watches the retiring instruction for
// exceptions, enabled interrupts and MRET. It then issues one-cycle
// mstatus/mepc/mcause commands and a fetch redirect with flush.
// All outputs come from flops. The value each output holds during a state
// is computed in the cycle that enters that state.
module trap_ctrl #(
  parameter int CODE_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        instr_valid_in,
  input  logic [31:0] pc_in,
  input  logic        misaligned_in,
  input  logic        illegal_in,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        mret_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        msie_in,
  input  logic        mtie_in,
  input  logic        meip_in,
  input  logic        msip_in,
  input  logic        mtip_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        set_epc_out,
  output logic [31:0] epc_out,
  output logic        set_cause_out,
  output logic [31:0] cause_out,
  output logic [1:0]  pc_sel_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    OPERATING   = 2'd0,
    TRAP_ENTER  = 2'd1,
    TRAP_RETURN = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_TVEC = 2'b01;
  localparam logic [1:0] SEL_EPC  = 2'b10;

  state_t state, state_nxt;

  // Candidate values for each output, registered together with the state.
  logic        mie_clear_nxt, mie_set_nxt, set_epc_nxt, set_cause_nxt, flush_nxt;
  logic [1:0]  pc_sel_nxt;
  logic [31:0] epc_nxt, cause_nxt, redirect_nxt;

  // The global MIE gates every interrupt source. It is sampled only in the
  // detection cycle.
  logic irq_e, irq_s, irq_t;
  assign irq_e = mie_in & meie_in & meip_in;
  assign irq_s = mie_in & msie_in & msip_in;
  assign irq_t = mie_in & mtie_in & mtip_in;

  logic              trap, is_irq;
  logic [CODE_W-1:0] code;
  logic [31:0]       code_ext, tvec_base, tvec_target, mret_target, cause_val;

  // Trap source select. Interrupts outrank exceptions.
  // Each class follows its fixed internal priority.
  always_comb begin
    trap   = 1'b0;
    is_irq = 1'b0;
    code   = '0;
    if (irq_e) begin
      trap = 1'b1; is_irq = 1'b1; code = CODE_W'(11);
    end else if (irq_s) begin
      trap = 1'b1; is_irq = 1'b1; code = CODE_W'(3);
    end else if (irq_t) begin
      trap = 1'b1; is_irq = 1'b1; code = CODE_W'(7);
    end else if (misaligned_in) begin
      trap = 1'b1; code = CODE_W'(0);
    end else if (illegal_in) begin
      trap = 1'b1; code = CODE_W'(2);
    end else if (ecall_in) begin
      trap = 1'b1; code = CODE_W'(11);
    end else if (ebreak_in) begin
      trap = 1'b1; code = CODE_W'(3);
    end
  end

  // Vector target computation. Only interrupts use the vectored offset.
  // Synchronous exceptions always land on the base address.
  always_comb begin
    code_ext  = 32'(code);
    tvec_base = mtvec_in & 32'hFFFF_FFFC;
    if (mtvec_in[1:0] == 2'b01 && is_irq)
      tvec_target = tvec_base + (code_ext << 2);
    else
      tvec_target = tvec_base;
    mret_target = mepc_in & 32'hFFFF_FFFE;
    cause_val   = code_ext | {is_irq, 31'b0};
  end

  // Next-state and next-output logic. epc/cause hold their value unless a
  // trap is being entered. All other outputs default to idle.
  always_comb begin
    state_nxt     = state;
    mie_clear_nxt = 1'b0;
    mie_set_nxt   = 1'b0;
    set_epc_nxt   = 1'b0;
    set_cause_nxt = 1'b0;
    flush_nxt     = 1'b0;
    pc_sel_nxt    = SEL_NONE;
    redirect_nxt  = 32'h0;
    epc_nxt       = epc_out;
    cause_nxt     = cause_out;
    case (state)
      OPERATING: begin
        if (instr_valid_in) begin
          if (trap) begin
            state_nxt     = TRAP_ENTER;
            mie_clear_nxt = 1'b1;
            set_epc_nxt   = 1'b1;
            set_cause_nxt = 1'b1;
            flush_nxt     = 1'b1;
            pc_sel_nxt    = SEL_TVEC;
            redirect_nxt  = tvec_target;
            epc_nxt       = pc_in;
            cause_nxt     = cause_val;
          end else if (mret_in) begin
            state_nxt    = TRAP_RETURN;
            mie_set_nxt  = 1'b1;
            flush_nxt    = 1'b1;
            pc_sel_nxt   = SEL_EPC;
            redirect_nxt = mret_target;
          end
        end
      end
      // Single-cycle states. All events are ignored here, which forces at
      // least one OPERATING cycle between consecutive traps.
      TRAP_ENTER:  state_nxt = OPERATING;
      TRAP_RETURN: state_nxt = OPERATING;
      default:     state_nxt = OPERATING;
    endcase
  end

  // State and output registers. Reset drops any trap in progress.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= OPERATING;
      mie_clear_out   <= 1'b0;
      mie_set_out     <= 1'b0;
      set_epc_out     <= 1'b0;
      set_cause_out   <= 1'b0;
      flush_out       <= 1'b0;
      pc_sel_out      <= SEL_NONE;
      redirect_pc_out <= 32'h0;
      epc_out         <= 32'h0;
      cause_out       <= 32'h0;
    end else begin
      state           <= state_nxt;
      mie_clear_out   <= mie_clear_nxt;
      mie_set_out     <= mie_set_nxt;
      set_epc_out     <= set_epc_nxt;
      set_cause_out   <= set_cause_nxt;
      flush_out       <= flush_nxt;
      pc_sel_out      <= pc_sel_nxt;
      redirect_pc_out <= redirect_nxt;
      epc_out         <= epc_nxt;
      cause_out       <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Inputs change 1ns after each rising edge.
// Outputs are checked 1ns after the edge that registers them.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        mis, ill, ecall, ebreak, mret;
  logic        mie, meie, msie, mtie, meip, msip, mtip;
  logic [31:0] mtvec, mepc;
  logic        mie_clr, mie_set, set_epc, set_cause, flush;
  logic [31:0] epc, cause, redir;
  logic [1:0]  pc_sel;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.CODE_W(4)) dut (
    .clk_in(clk), .rst_in(rst), .instr_valid_in(valid), .pc_in(pc),
    .misaligned_in(mis), .illegal_in(ill), .ecall_in(ecall),
    .ebreak_in(ebreak), .mret_in(mret), .mie_in(mie),
    .meie_in(meie), .msie_in(msie), .mtie_in(mtie),
    .meip_in(meip), .msip_in(msip), .mtip_in(mtip),
    .mtvec_in(mtvec), .mepc_in(mepc),
    .mie_clear_out(mie_clr), .mie_set_out(mie_set),
    .set_epc_out(set_epc), .epc_out(epc),
    .set_cause_out(set_cause), .cause_out(cause),
    .pc_sel_out(pc_sel), .redirect_pc_out(redir), .flush_out(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b1; pc = 32'h0;
    mis = 0; ill = 0; ecall = 0; ebreak = 0; mret = 0;
    mie = 0; meie = 0; msie = 0; mtie = 0; meip = 0; msip = 0; mtip = 0;
  endtask

  // Checks the strobe and redirect outputs as one group.
  task automatic chk_ctl(input string tag, input logic clr, input logic set,
                         input logic sepc, input logic scause, input logic fl,
                         input logic [1:0] sel, input logic [31:0] rd);
    chk({tag, ".mie_clear"}, 32'(mie_clr), 32'(clr));
    chk({tag, ".mie_set"},   32'(mie_set), 32'(set));
    chk({tag, ".set_epc"},   32'(set_epc), 32'(sepc));
    chk({tag, ".set_cause"}, 32'(set_cause), 32'(scause));
    chk({tag, ".flush"},     32'(flush), 32'(fl));
    chk({tag, ".pc_sel"},    32'(pc_sel), 32'(sel));
    chk({tag, ".redirect"},  redir, rd);
  endtask

  initial begin
    idle();
    mtvec = 32'h0; mepc = 32'h0;
    rst = 1'b1;
    step(); step();
    chk_ctl("rst", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.cause", cause, 32'h0);

    // Idle with a valid instruction and no events.
    rst = 1'b0;
    step(); step();
    chk_ctl("idle", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("idle.epc", epc, 32'h0);

    // Illegal instruction in vectored mode still uses the base address.
    pc = 32'h100; ill = 1; mtvec = 32'h41;
    step(); idle();
    chk_ctl("ill", 1, 0, 1, 1, 1, 2'b01, 32'h40);
    chk("ill.epc", epc, 32'h100);
    chk("ill.cause", cause, 32'h2);
    step();
    chk_ctl("ill_after", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("ill_after.epc_hold", epc, 32'h100);
    chk("ill_after.cause_hold", cause, 32'h2);

    // Vectored timer interrupt.
    mie = 1; mtie = 1; mtip = 1; mtvec = 32'h201; pc = 32'h80;
    step(); idle();
    chk_ctl("tmr", 1, 0, 1, 1, 1, 2'b01, 32'h21C);
    chk("tmr.cause", cause, 32'h8000_0007);
    chk("tmr.epc", epc, 32'h80);
    step();

    // All interrupt sources pending plus ECALL: external wins.
    mie = 1; meie = 1; msie = 1; mtie = 1; meip = 1; msip = 1; mtip = 1;
    ecall = 1; pc = 32'h300;
    step(); idle();
    chk("prio.cause", cause, 32'h8000_000B);
    chk("prio.redirect", redir, 32'h22C);
    step();
    // The same inputs with MIE clear take the ECALL exception instead.
    meie = 1; msie = 1; mtie = 1; meip = 1; msip = 1; mtip = 1; ecall = 1;
    step(); idle();
    chk("prio_nomie.cause", cause, 32'h0000_000B);
    chk("prio_nomie.redirect", redir, 32'h200);
    step();

    // MRET redirects to mepc with bit 0 cleared.
    mret = 1; mepc = 32'h105;
    step(); idle();
    chk_ctl("mret", 0, 1, 0, 0, 1, 2'b10, 32'h104);
    chk("mret.cause_hold", cause, 32'hB);
    step();
    chk_ctl("mret_after", 0, 0, 0, 0, 0, 2'b00, 32'h0);

    // MRET together with EBREAK traps with cause 3.
    mret = 1; ebreak = 1; pc = 32'h44;
    step(); idle();
    chk_ctl("mret_ebrk", 1, 0, 1, 1, 1, 2'b01, 32'h200);
    chk("mret_ebrk.cause", cause, 32'h3);
    step();

    // An invalid instruction ignores all events.
    valid = 0; ill = 1; mret = 1; mie = 1; meie = 1; meip = 1;
    step(); idle();
    chk_ctl("novalid", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("novalid.cause_hold", cause, 32'h3);

    // A held exception is ignored in TRAP_ENTER, then traps again one cycle later.
    mis = 1; pc = 32'h500;
    step();
    chk("b2b.first", 32'(set_epc), 32'h1);
    chk("b2b.cause", cause, 32'h0);
    step();
    chk("b2b.gap", 32'(set_epc), 32'h0);
    step(); idle();
    chk("b2b.second", 32'(set_epc), 32'h1);
    step();

    // Reset asserted during TRAP_ENTER drops the trap.
    ecall = 1; pc = 32'h600;
    step(); idle();
    chk("rstmid.enter", 32'(mie_clr), 32'h1);
    rst = 1;
    step();
    chk_ctl("rstmid", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("rstmid.epc", epc, 32'h0);
    chk("rstmid.cause", cause, 32'h0);
    rst = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule
